id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of PC and data paths.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of bubble counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ctrl_i  input  11  decoder bundle {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,BranchNE,BranchEQ,ALUOp[2:0]}, MSB first.
REQ-006 SHALL have port valid_i  input  1  decode slot holds a real instruction.
REQ-007 SHALL have ports pc4_i, rs_data_i, rt_data_i, imm_i  input  DATA_WIDTH each  PC+4, register-file reads, sign-extended immediate.
REQ-008 SHALL have ports rs_i, rt_i, rd_i  input  5 each  instruction register fields.
REQ-009 SHALL have port stall_i  input  1  execute stage cannot accept; hold contents.
REQ-010 SHALL have port flush_i  input  1  taken branch/jump; squash decode slot.
REQ-011 SHALL have ports ctrl_o (11), valid_o (1), pc4_o, rs_data_o, rt_data_o, imm_o (DATA_WIDTH), rs_o, rt_o (5)  output  registered copies.
REQ-012 SHALL have port write_reg_o  output  5  registered destination: rd_i if RegDst else rt_i.
REQ-013 SHALL have port stall_o  output  1  combinational load-use hazard request to PC and IF/ID register.
REQ-014 SHALL have port bubble_cnt_o  output  CNT_WIDTH  count of bubbles inserted.

Function
REQ-015 Per-edge priority SHALL be: reset > flush_i > stall_i > hazard > load.
REQ-016 flush_i=1 SHALL load a bubble: valid_o=0, ctrl_o=0, data outputs don't-care but SHALL be zeroed.
REQ-017 stall_i=1 with flush_i=0 SHALL hold every registered output unchanged; stall_o SHALL still be evaluated.
REQ-018 Hazard SHALL be: valid_o & ctrl_o[MemRead] & (rt_o!=0) & valid_i & (rt_o==rs_i | rt_o==rt_i).
REQ-019 stall_o SHALL equal hazard & ~flush_i.
REQ-020 Hazard with stall_i=0, flush_i=0 SHALL load a bubble (as REQ-016) for exactly one cycle; the held decode instruction SHALL load on the following edge.
REQ-021 Otherwise the stage SHALL load all inputs; valid_o=valid_i, and ctrl_o SHALL be forced 0 when valid_i=0.
REQ-022 Latency input-to-output SHALL be exactly one cycle when no stall/flush/hazard.
REQ-023 bubble_cnt_o SHALL increment by one on every edge that loads a bubble via REQ-016 or REQ-020 and SHALL saturate at all-ones.
REQ-024 ALUOp and all ctrl bits SHALL pass unmodified; no decoding in this block.

Reset
REQ-025 reset=1 at an edge SHALL clear valid_o, ctrl_o, all data outputs, write_reg_o, and bubble_cnt_o to 0, overriding all other inputs.
REQ-026 After reset stall_o SHALL be 0 (valid_o=0); reset mid-stall SHALL drop the held instruction.

Configuration
REQ-027 Macro ID_EX_HAZARD_DETECT_EN SHALL control load-use detection.
REQ-028 Defined: REQ-018..REQ-020 active. Undefined: hazard tied 0, stall_o constant 0, bubbles only from flush_i.

Verification
REQ-029 Reset, then R-type ctrl_i=11'b1_001_00_00_111, rd_i=5, rt_i=3, valid_i=1 -> next edge ctrl_o=11'b10010000111, write_reg_o=5, valid_o=1.
REQ-030 LW (ctrl MemRead=1, rt=8) followed by ADD rs_i=8 -> stall_o=1 same cycle; next edge valid_o=0, ctrl_o=0, bubble_cnt_o=1; following edge ADD loaded.
REQ-031 Same as REQ-030 with rt_o=0 -> stall_o=0, no bubble.
REQ-032 stall_i=1 for 3 cycles with changing inputs -> all outputs constant; flush_i=1 asserted with stall_i=1 -> valid_o=0 next edge.
REQ-033 Force bubble_cnt_o to all-ones region via 2^CNT_WIDTH+2 flushes (CNT_WIDTH=4) -> bubble_cnt_o=15 held.
REQ-034 Build without ID_EX_HAZARD_DETECT_EN, repeat REQ-030 -> stall_o=0, ADD loaded directly, bubble_cnt_o=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with load-use bubble insertion.
//
// Captures the decoded instruction (control bundle, operands, register fields)
// between decode and execute. Per edge, the priority is:
// reset > flush_i > stall_i > load-use hazard > load.
// A flush or a hazard loads a bubble (valid/ctrl/data all zero), and
// bubble_cnt_o counts bubbles, saturating at all-ones.
//
// Optional feature: define ID_EX_HAZARD_DETECT_EN to enable load-use detection
// and stall_o. When it is undefined, stall_o is constant 0 and bubbles come
// only from flush_i.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   ctrl_i[10:0]      {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,
//                      BranchNE,BranchEQ,ALUOp[2:0]}, passed through unmodified
//   valid_i           decode slot holds a real instruction
//   pc4_i, rs_data_i, rt_data_i, imm_i   DATA_WIDTH data paths
//   rs_i, rt_i, rd_i  register fields
//   stall_i           execute cannot accept; hold contents
//   flush_i           squash the decode slot (load a bubble)
//   ctrl_o, valid_o, pc4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o
//                     registered copies of the inputs
//   write_reg_o       registered destination (rd_i if RegDst else rt_i)
//   stall_o           combinational load-use stall request to PC and IF/ID
//   bubble_cnt_o      saturating count of inserted bubbles
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           ctrl_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] pc4_i,
    input  logic [DATA_WIDTH-1:0] rs_data_i,
    input  logic [DATA_WIDTH-1:0] rt_data_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [4:0]            rs_i,
    input  logic [4:0]            rt_i,
    input  logic [4:0]            rd_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic [10:0]           ctrl_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] pc4_o,
    output logic [DATA_WIDTH-1:0] rs_data_o,
    output logic [DATA_WIDTH-1:0] rt_data_o,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic [4:0]            rs_o,
    output logic [4:0]            rt_o,
    output logic [4:0]            write_reg_o,
    output logic                  stall_o,
    output logic [CNT_WIDTH-1:0]  bubble_cnt_o
);

    localparam int unsigned CTRL_W      = 11;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned REGDST_BIT  = 10;
    localparam int unsigned MEMREAD_BIT = 6;

`ifdef ID_EX_HAZARD_DETECT_EN
    localparam bit HAZARD_EN = 1'b1;
`else
    localparam bit HAZARD_EN = 1'b0;
`endif

    logic [CTRL_W-1:0]     ctrl_q,      ctrl_d;
    logic                  valid_q,     valid_d;
    logic [DATA_WIDTH-1:0] pc4_q,       pc4_d;
    logic [DATA_WIDTH-1:0] rs_data_q,   rs_data_d;
    logic [DATA_WIDTH-1:0] rt_data_q,   rt_data_d;
    logic [DATA_WIDTH-1:0] imm_q,       imm_d;
    logic [REG_W-1:0]      rs_q,        rs_d;
    logic [REG_W-1:0]      rt_q,        rt_d;
    logic [REG_W-1:0]      write_reg_q, write_reg_d;
    logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;

    logic hazard_c;
    logic bubble_c;
    logic load_c;

    // Load-use hazard: a load in EX whose destination feeds the instruction in ID.
    // A zero destination is never a real dependency.
    always_comb begin
        hazard_c = HAZARD_EN && valid_q && ctrl_q[MEMREAD_BIT] && (rt_q != '0)
                   && valid_i && ((rt_q == rs_i) || (rt_q == rt_i));
        stall_o  = hazard_c & ~flush_i;
    end

    // Edge action decode: flush beats stall, stall beats hazard, hazard beats load.
    always_comb begin
        bubble_c = 1'b0;
        load_c   = 1'b0;
        if (flush_i) begin
            bubble_c = 1'b1;
        end else if (stall_i) begin
            bubble_c = 1'b0;
        end else if (hazard_c) begin
            bubble_c = 1'b1;
        end else begin
            load_c = 1'b1;
        end
    end

    // Next-state values; holding is the default.
    always_comb begin
        ctrl_d      = ctrl_q;
        valid_d     = valid_q;
        pc4_d       = pc4_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        write_reg_d = write_reg_q;
        cnt_d       = cnt_q;

        if (bubble_c) begin
            ctrl_d      = '0;
            valid_d     = 1'b0;
            pc4_d       = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            rs_d        = '0;
            rt_d        = '0;
            write_reg_d = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else if (load_c) begin
            // An empty slot never carries live control bits into execute.
            ctrl_d      = valid_i ? ctrl_i : CTRL_W'(0);
            valid_d     = valid_i;
            pc4_d       = pc4_i;
            rs_data_d   = rs_data_i;
            rt_data_d   = rt_data_i;
            imm_d       = imm_i;
            rs_d        = rs_i;
            rt_d        = rt_i;
            write_reg_d = ctrl_i[REGDST_BIT] ? rd_i : rt_i;
        end
    end

    // Pipeline state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            valid_q     <= 1'b0;
            pc4_q       <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            write_reg_q <= '0;
            cnt_q       <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            valid_q     <= valid_d;
            pc4_q       <= pc4_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            write_reg_q <= write_reg_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ctrl_o       = ctrl_q;
    assign valid_o      = valid_q;
    assign pc4_o        = pc4_q;
    assign rs_data_o    = rs_data_q;
    assign rt_data_o    = rt_data_q;
    assign imm_o        = imm_q;
    assign rs_o         = rs_q;
    assign rt_o         = rt_q;
    assign write_reg_o  = write_reg_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage -- scoreboard bench for id_ex_stage.
// The driver applies one directed vector per cycle at the falling edge and
// pushes the hand-computed expectation (stall_o before the next rising edge,
// registered outputs after it). A separate monitor pops and compares.
// Data inputs use a per-vector base: pc4=base, rs_data=base+1, rt_data=base+2,
// imm=base+3.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

`ifdef ID_EX_HAZARD_DETECT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    localparam logic [10:0] C_R  = 11'b1_001_00_00_111;
    localparam logic [10:0] C_LW = 11'b0_111_10_00_000;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   ctrl_i;
    logic          valid_i;
    logic [DW-1:0] pc4_i, rs_data_i, rt_data_i, imm_i;
    logic [4:0]    rs_i, rt_i, rd_i;
    logic          stall_i, flush_i;
    logic [10:0]   ctrl_o;
    logic          valid_o;
    logic [DW-1:0] pc4_o, rs_data_o, rt_data_o, imm_o;
    logic [4:0]    rs_o, rt_o, write_reg_o;
    logic          stall_o;
    logic [CW-1:0] bubble_cnt_o;

    id_ex_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .ctrl_i(ctrl_i), .valid_i(valid_i),
        .pc4_i(pc4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .stall_i(stall_i), .flush_i(flush_i),
        .ctrl_o(ctrl_o), .valid_o(valid_o), .pc4_o(pc4_o), .rs_data_o(rs_data_o),
        .rt_data_o(rt_data_o), .imm_o(imm_o), .rs_o(rs_o), .rt_o(rt_o),
        .write_reg_o(write_reg_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          chk_stall;
        logic        stall;
        logic [10:0] ctrl;
        logic        valid;
        logic [4:0]  wr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] base;
        bit          zero;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %0h expected %0h", nm, id, got, exp);
        end
    endtask

    task automatic drv(input logic rst, input logic fl, input logic st, input logic [10:0] c,
                       input logic v, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [31:0] b);
        reset = rst; flush_i = fl; stall_i = st; ctrl_i = c; valid_i = v;
        rs_i = s; rt_i = t; rd_i = d;
        pc4_i = b; rs_data_i = b + 1; rt_data_i = b + 2; imm_i = b + 3;
    endtask

    task automatic ex(input int id, input bit cs, input logic es, input logic [10:0] c,
                      input logic v, input logic [4:0] w, input logic [4:0] s,
                      input logic [4:0] t, input logic [31:0] b, input bit z);
        exp_t e;
        e.id = id; e.chk_stall = cs; e.stall = es; e.ctrl = c; e.valid = v;
        e.wr = w; e.rs = s; e.rt = t; e.base = b; e.zero = z; e.cnt = CW'(ecnt);
        sbq.push_back(e);
    endtask

    task automatic ex_bubble(input int id, input logic es);
        ex(id, 1'b1, es, 11'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    endtask

    // Monitor: stall_o just before the rising edge, registered outputs just after.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sbq.size() != 0) begin
                e = sbq[0];
                if (e.chk_stall) chk("stall_o", e.id, 32'(stall_o), 32'(e.stall));
                @(posedge clk);
                #1;
                e = sbq.pop_front();
                chk("ctrl_o",       e.id, 32'(ctrl_o),       32'(e.ctrl));
                chk("valid_o",      e.id, 32'(valid_o),      32'(e.valid));
                chk("write_reg_o",  e.id, 32'(write_reg_o),  32'(e.wr));
                chk("rs_o",         e.id, 32'(rs_o),         32'(e.rs));
                chk("rt_o",         e.id, 32'(rt_o),         32'(e.rt));
                chk("pc4_o",        e.id, pc4_o,     e.zero ? 32'd0 : e.base);
                chk("rs_data_o",    e.id, rs_data_o, e.zero ? 32'd0 : e.base + 1);
                chk("rt_data_o",    e.id, rt_data_o, e.zero ? 32'd0 : e.base + 2);
                chk("imm_o",        e.id, imm_o,     e.zero ? 32'd0 : e.base + 3);
                chk("bubble_cnt_o", e.id, 32'(bubble_cnt_o), 32'(e.cnt));
            end
        end
    end

    // Driver
    initial begin
        drv(1, 0, 0, C_R, 1, 1, 3, 5, 100);

        // Reset (state unknown before the first edge, so stall_o unchecked)
        @(negedge clk); drv(1, 0, 0, C_R, 1, 1, 3, 5, 100);
        ex(0, 1'b0, 1'b0, 11'd0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drv(1, 0, 0, C_R, 1, 1, 3, 5, 100);
        ex(1, 1'b1, 1'b0, 11'd0, 0, 0, 0, 0, 0, 1);

        // R-type: write_reg = rd
        @(negedge clk); drv(0, 0, 0, C_R, 1, 1, 3, 5, 100);
        ex(2, 1, 0, C_R, 1, 5, 1, 3, 100, 0);
        // LW rt=8: write_reg = rt
        @(negedge clk); drv(0, 0, 0, C_LW, 1, 2, 8, 0, 200);
        ex(3, 1, 0, C_LW, 1, 8, 2, 8, 200, 0);
        // ADD rs=8 depends on the load
        @(negedge clk); drv(0, 0, 0, C_R, 1, 8, 9, 10, 300);
        if (HZ) begin ecnt++; ex_bubble(4, 1'b1); end
        else ex(4, 1, 0, C_R, 1, 10, 8, 9, 300, 0);
        // ADD held upstream loads now
        @(negedge clk); drv(0, 0, 0, C_R, 1, 8, 9, 10, 300);
        ex(5, 1, 0, C_R, 1, 10, 8, 9, 300, 0);

        // Load to r0 never stalls
        @(negedge clk); drv(0, 0, 0, C_LW, 1, 4, 0, 0, 400);
        ex(6, 1, 0, C_LW, 1, 0, 4, 0, 400, 0);
        @(negedge clk); drv(0, 0, 0, C_R, 1, 0, 0, 11, 500);
        ex(7, 1, 0, C_R, 1, 11, 0, 0, 500, 0);

        // Invalid slot after a load: no hazard, ctrl forced to 0
        @(negedge clk); drv(0, 0, 0, C_LW, 1, 1, 7, 0, 600);
        ex(8, 1, 0, C_LW, 1, 7, 1, 7, 600, 0);
        @(negedge clk); drv(0, 0, 0, C_LW, 0, 7, 7, 12, 700);
        ex(9, 1, 0, 11'd0, 0, 7, 7, 7, 700, 0);

        // Hazard through rt field
        @(negedge clk); drv(0, 0, 0, C_LW, 1, 3, 6, 0, 800);
        ex(10, 1, 0, C_LW, 1, 6, 3, 6, 800, 0);
        @(negedge clk); drv(0, 0, 0, C_R, 1, 1, 6, 13, 900);
        if (HZ) begin ecnt++; ex_bubble(11, 1'b1); end
        else ex(11, 1, 0, C_R, 1, 13, 1, 6, 900, 0);
        @(negedge clk); drv(0, 0, 0, C_R, 1, 1, 6, 13, 900);
        ex(12, 1, 0, C_R, 1, 13, 1, 6, 900, 0);

        // stall_i for 3 cycles with changing inputs: hold
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drv(0, 0, 1, (i == 1) ? C_R : C_LW, 1, 5'(13 + i), 5'(13 + i), 5'(2 + i), 32'(1000 + 100 * i));
            ex(13 + i, 1, 0, C_R, 1, 13, 1, 6, 900, 0);
        end

        // Hazard during stall_i: stall_o raised, contents held, no bubble
        @(negedge clk); drv(0, 0, 0, C_LW, 1, 2, 9, 0, 1300);
        ex(16, 1, 0, C_LW, 1, 9, 2, 9, 1300, 0);
        @(negedge clk); drv(0, 0, 1, C_R, 1, 9, 1, 14, 1400);
        ex(17, 1, HZ, C_LW, 1, 9, 2, 9, 1300, 0);
        // flush wins over stall and masks stall_o
        @(negedge clk); drv(0, 1, 1, C_R, 1, 9, 1, 14, 1400);
        ecnt++; ex_bubble(18, 1'b0);
        @(negedge clk); drv(0, 0, 0, C_R, 1, 9, 1, 14, 1400);
        ex(19, 1, 0, C_R, 1, 14, 9, 1, 1400, 0);

        // Reset mid-stall drops the held instruction and clears the counter
        @(negedge clk); drv(0, 0, 0, C_LW, 1, 5, 4, 0, 1500);
        ex(20, 1, 0, C_LW, 1, 4, 5, 4, 1500, 0);
        @(negedge clk); drv(1, 0, 1, C_R, 1, 4, 2, 15, 1600);
        ecnt = 0; ex(21, 1, HZ, 11'd0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); drv(0, 0, 0, C_R, 1, 4, 2, 15, 1600);
        ex(22, 1, 0, C_R, 1, 15, 4, 2, 1600, 0);

        // 2^CW+2 flushes: counter saturates at 15
        for (int i = 0; i < 18; i++) begin
            @(negedge clk); drv(0, 1, 0, C_LW, 1, 4, 2, 0, 32'(1700 + i));
            if (ecnt < 15) ecnt++;
            ex_bubble(23 + i, 1'b0);
        end

        // Final reset clears the saturated counter
        @(negedge clk); drv(1, 0, 0, C_R, 1, 1, 2, 3, 2000);
        ecnt = 0; ex(41, 1, 0, 11'd0, 0, 0, 0, 0, 0, 1);

        @(negedge clk); drv(1, 0, 0, C_R, 1, 1, 2, 3, 2000);
        for (int k = 0; k < 10 && sbq.size() != 0; k++) @(posedge clk);
        #3;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
